// File: rtl/divs_fx_pkg.sv
// Shared types and helpers for the iterative fixed-point divider.
package divs_fx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int MAXW = 64;

    typedef logic [MAXW-1:0] wide_t;

    function automatic int iter_of(input int width, input int fbits, input int round);
        return width + fbits + ((round != 0) ? 1 : 0);
    endfunction

    function automatic wide_t low_mask(input int width);
        if (width >= MAXW)
            return '1;
        return (wide_t'(1) << width) - wide_t'(1);
    endfunction

    // Magnitude of a width-bit operand; -2^(w-1) maps to 2^(w-1).
    function automatic wide_t abs_mag(input wide_t v, input int width, input bit sgn);
        wide_t m;
        bit    msb;
        m   = v & low_mask(width);
        msb = |(m & (wide_t'(1) << (width - 1)));
        if (sgn && msb)
            m = (~m + wide_t'(1)) & low_mask(width);
        return m;
    endfunction

    function automatic wide_t sat_limit(input int width, input bit sgn, input bit neg);
        if (!sgn)
            return low_mask(width);
        if (neg)
            return wide_t'(1) << (width - 1);
        return low_mask(width - 1);
    endfunction

endpackage

// File: rtl/divs_fx.sv
// Iterative restoring fixed-point divider, one quotient bit per clock.
// Handles sign, rounding, saturation and divide-by-zero around the core.
module divs_fx
    import divs_fx_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FBITS  = 8,
    parameter int SIGNED = 1,
    parameter int ROUND  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             dbz,
    output logic             ovf,
    output logic             busy
);

    localparam int ITER = iter_of(WIDTH, FBITS, ROUND);
    localparam int CW   = $clog2(ITER + 1);
    localparam int MW   = ITER + 1;
    localparam bit SG   = (SIGNED != 0);

    localparam logic [CW-1:0]    LAST   = CW'(ITER - 1);
    localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(sat_limit(WIDTH, SG, 1'b0));

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH:0]   rem;
    logic [ITER-1:0]  qm;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_nxt;
    logic             qbit;
    logic [MW-1:0]    mag;
    logic [MW-1:0]    lim;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        a_mag   = WIDTH'(abs_mag(wide_t'(a), WIDTH, SG));
        b_mag   = WIDTH'(abs_mag(wide_t'(b), WIDTH, SG));
        a_neg   = SG & a[WIDTH-1];
        b_neg   = SG & b[WIDTH-1];
        lim     = MW'(sat_limit(WIDTH, SG, neg));
        rem_sh  = {rem[WIDTH-1:0], a_sh[WIDTH-1]};
        qbit    = (rem_sh >= {1'b0, bm});
        rem_nxt = qbit ? (rem_sh - {1'b0, bm}) : rem_sh;
        // The guard bit rounds the magnitude half-up before range checking.
        if (ROUND != 0)
            mag = ({1'b0, qm} >> 1) + MW'(qm[0]);
        else
            mag = {1'b0, qm};

        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid)
                    state_nxt = (b == '0) ? DONE : CALC;
            end
            CALC: begin
                if (cnt == LAST)
                    state_nxt = FIX;
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            q         <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
            bm        <= '0;
            a_sh      <= '0;
            rem       <= '0;
            qm        <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        bm   <= b_mag;
                        a_sh <= a_mag;
                        rem  <= '0;
                        qm   <= '0;
                        cnt  <= '0;
                        neg  <= a_neg ^ b_neg;
                        dbz  <= 1'b0;
                        ovf  <= 1'b0;
                        if (b == '0) begin
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            if (a == '0)
                                q <= '0;
                            else if (a_neg)
                                q <= MINNEG;
                            else
                                q <= MAXPOS;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_nxt;
                    qm   <= {qm[ITER-2:0], qbit};
                    a_sh <= a_sh << 1;
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    out_valid <= 1'b1;
                    if (mag > lim) begin
                        ovf <= 1'b1;
                        q   <= neg ? MINNEG : lim[WIDTH-1:0];
                    end else begin
                        q <= neg ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divs_fx.sv
// Directed bench for divs_fx: three configurations, scoreboard model,
// literal vectors, latency, backpressure and mid-operation reset.
module tb_divs_fx;

    typedef struct {
        logic [15:0] q;
        logic        dbz;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  dbz;
    logic [2:0]  ovf;
    logic [2:0]  busy;
    logic [15:0] a [3];
    logic [15:0] b [3];
    logic [15:0] q [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    // 0: signed+round, 1: signed truncating, 2: unsigned+round
    for (genvar i = 0; i < 3; i++) begin : g_dut
        divs_fx #(
            .WIDTH (16),
            .FBITS (8),
            .SIGNED((i == 2) ? 0 : 1),
            .ROUND ((i == 1) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[i]),
            .in_ready (in_ready[i]),
            .a        (a[i]),
            .b        (b[i]),
            .out_valid(out_valid[i]),
            .out_ready(out_ready[i]),
            .q        (q[i]),
            .dbz      (dbz[i]),
            .ovf      (ovf[i]),
            .busy     (busy[i])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Real-valued quotient in Q8.8, rounded half away from zero or truncated.
    function automatic res_t model(input logic [15:0] ta, input logic [15:0] tb,
                                   input bit sgn, input bit rnd);
        res_t   r;
        longint av, bv, am, bmg, mag, v, lo, hi;
        av = sgn ? longint'($signed(ta)) : longint'(ta);
        bv = sgn ? longint'($signed(tb)) : longint'(tb);
        r.dbz = 1'b0;
        r.ovf = 1'b0;
        if (bv == 0) begin
            r.dbz = 1'b1;
            if (av == 0)
                r.q = 16'h0000;
            else if (av < 0)
                r.q = 16'h8000;
            else
                r.q = sgn ? 16'h7FFF : 16'hFFFF;
            return r;
        end
        am  = (av < 0) ? -av : av;
        bmg = (bv < 0) ? -bv : bv;
        if (rnd)
            mag = ((am * 512) / bmg + 1) / 2;
        else
            mag = (am * 256) / bmg;
        v  = ((av < 0) != (bv < 0)) ? -mag : mag;
        lo = sgn ? -32768 : 0;
        hi = sgn ? 32767 : 65535;
        if (v > hi) begin
            r.ovf = 1'b1;
            r.q   = 16'(hi);
        end else if (v < lo) begin
            r.ovf = 1'b1;
            r.q   = 16'(lo);
        end else begin
            r.q = 16'(v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid[0]) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale: out_valid with no pending op, q=%0h", q[0]);
            end else begin
                chk("sb_q", q[0], sb[0].q);
                chk("sb_dbz", dbz[0], sb[0].dbz);
                chk("sb_ovf", ovf[0], sb[0].ovf);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid[0] && out_ready[0] && sb.size() > 0)
            void'(sb.pop_front());
    end

    task automatic op(input int k, input logic [15:0] ta, input logic [15:0] tb,
                      input logic [15:0] eq, input logic ed, input logic eo,
                      input int elat, input int hold);
        res_t m;
        int   lat;
        m = model(ta, tb, k != 2, k != 1);
        chk("model_q", m.q, eq);
        chk("model_dbz", m.dbz, ed);
        chk("model_ovf", m.ovf, eo);
        @(negedge clk);
        chk("in_ready_idle", in_ready[k], 1'b1);
        a[k] = ta;
        b[k] = tb;
        in_valid[k] = 1'b1;
        @(posedge clk);
        if (k == 0)
            sb.push_back(m);
        #1;
        in_valid[k] = 1'b0;
        a[k] = 16'($urandom);
        b[k] = 16'($urandom);
        lat = 1;
        while (!out_valid[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("q_lit", q[k], eq);
        chk("dbz_lit", dbz[k], ed);
        chk("ovf_lit", ovf[k], eo);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid[k] = 1'b1;
            a[k] = 16'h1234;
            b[k] = 16'h0001;
            chk("hold_in_ready", in_ready[k], 1'b0);
            chk("hold_valid", out_valid[k], 1'b1);
            chk("hold_q", q[k], eq);
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        chk("drop_valid", out_valid[k], 1'b0);
        chk("back_idle", in_ready[k], 1'b1);
    endtask

    initial begin
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid[0], 1'b0);
        chk("rst_q", q[0], 16'h0000);
        chk("rst_dbz", dbz[0], 1'b0);
        chk("rst_ovf", ovf[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_ready", in_ready[0], 1'b1);

        op(0, 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 27, 0);
        op(0, 16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 27, 0);
        op(0, 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 27, 0);
        op(0, 16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0, 27, 0);
        op(0, 16'hFE00, 16'h0300, 16'hFF55, 1'b0, 1'b0, 27, 0);
        op(0, 16'h7F00, 16'h0080, 16'h7FFF, 1'b0, 1'b1, 27, 0);
        op(0, 16'h8000, 16'h0080, 16'h8000, 1'b0, 1'b1, 27, 0);
        op(0, 16'h0500, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1, 0);
        op(0, 16'hFB00, 16'h0000, 16'h8000, 1'b1, 1'b0, 1, 0);
        op(0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 0);
        op(0, 16'h0300, 16'hFE00, 16'hFE80, 1'b0, 1'b0, 27, 20);
        op(1, 16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0, 26, 0);
        op(2, 16'hFF00, 16'h0080, 16'hFFFF, 1'b0, 1'b1, 27, 0);

        // Reset in the middle of a calculation must discard the operation.
        @(negedge clk);
        a[0] = 16'h0300;
        b[0] = 16'h0200;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy[0], 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid[0], 1'b0);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_ready", in_ready[0], 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("no_stale", out_valid[0], 1'b0);
        op(0, 16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0, 27, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
